rpt_add_mult: RTL and testbench
===============================

Name: rpt_add_mult

Overview:
- Parametrised sequential multiplier using repeated addition: product = a × b, built by adding A to an accumulator B times.
- Replaces the fixed-width controller plus separate datapath with one block that holds FSM, operand registers, down-counter and accumulator.
- Adds a start/ready/done handshake, an abort input, and an optional latency-reducing operand swap.
- Sits as a leaf arithmetic unit under any sequencer needing an unsigned multiply without a hardware multiplier.

Parameters:
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- abort  input  1  synchronous cancel of an operation in flight
- a_in  input  WIDTH  multiplicand, sampled on the accepting edge
- b_in  input  WIDTH  multiplier (repeat count), sampled on the accepting edge
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held until the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, product=0; internal A, B and accumulator cleared.
- States: IDLE, RUN, DONE (2-bit encoding); the default branch returns to IDLE.
- IDLE, start=1 at a clock edge:
  - A←a_in, B←b_in, ACC←0, go to RUN.
  - start=0: remain in IDLE.
- RUN, each cycle:
  - abort=1: go to IDLE; ACC, product and done untouched. abort has priority over everything else.
  - B==0: product←ACC, go to DONE.
  - otherwise: ACC←ACC+A (zero-extended to 2*WIDTH; cannot overflow), B←B−1.
- DONE: done=1 for exactly this cycle, busy=1, then go to IDLE unconditionally. abort is ignored in DONE.
- Latency:
  - With start accepted at edge 0, RUN lasts b+1 cycles and done is high in cycle b+2.
  - The next start can be accepted at the edge that leaves DONE+1, i.e. in IDLE.
- start while not ready: ignored, not queued.
- abort in IDLE: no effect.
- b=0: a single RUN cycle, then done with product=0.
- a=0: full b+1 RUN cycles, then product=0.
- Maximum operands (2^WIDTH−1 each): product=(2^WIDTH−1)^2, with no wrap.
- product changes only on the RUN→DONE transition or on reset; it is stable across IDLE and across an aborted operation.
- rst_n asserted mid-RUN: immediate return to IDLE with all reset values, no done.

Optional Feature:
- Macro: RPT_MULT_OPERAND_SWAP_EN.
- Defined: on the accepting edge, if b_in > a_in, then A←b_in and B←a_in. The loop count is min(a,b) and the done cycle is min(a,b)+2. product is identical.
- Undefined: no comparator; loop count is always b_in.

Decomposition:
- Package rpt_mult_pkg holds:
  - the state typedef/encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - a default WIDTH constant.
- One sub-module is natural: rpt_mult_ctrl, the FSM. Inputs: start, abort, b_zero. Outputs: load, step, latch_p, ready, busy, done.
- The top holds the datapath: registers, adder, decrementer, swap compare.

Test Plan:
- Reset checks:
  - rst_n low, then released → ready=1, busy=0, done=0, product=0.
  - Reset asserted during RUN → same values, no done pulse.
- Basic multiply (WIDTH=8): a=5, b=3, start for 1 cycle → done in cycle 5 after accept, product=15, ready back the cycle after.
- Boundaries:
  - a=7, b=0 → done in cycle 2, product=0.
  - a=0, b=4 → done in cycle 6, product=0.
  - a=255, b=255 → product=65025, done in cycle 257.
- Abort and ignored start:
  - Start a=9, b=10; abort in the 4th RUN cycle → IDLE next cycle, no done, product keeps the previous value (15).
  - start pulsed while busy → ignored, first result unaffected.
- Swap feature: a=2, b=200 with RPT_MULT_OPERAND_SWAP_EN → product=400, done in cycle 4; without the macro → done in cycle 202.
- Back-to-back operations: start held high continuously with changing operands → each operation accepted only in IDLE, one done pulse per operation, each product correct, 3 operations checked against a reference model.

Source files
------------

// File: rtl/rpt_mult_pkg.sv
// rpt_mult_pkg: shared state encoding and defaults for the
// repeated-addition multiplier.
package rpt_mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rpt_mult_ctrl.sv
// rpt_mult_ctrl: IDLE/RUN/DONE sequencer for rpt_add_mult.
// Status outputs are registered alongside the state.
module rpt_mult_ctrl
  import rpt_mult_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic b_zero,
  output logic load,
  output logic step,
  output logic latch_p,
  output logic ready,
  output logic busy,
  output logic done
);

  state_t state;

  logic in_idle;
  logic in_run;

  assign in_idle = (state == IDLE);
  assign in_run  = (state == RUN);

  assign load    = in_idle & start;
  assign step    = in_run & ~abort & ~b_zero;
  assign latch_p = in_run & ~abort & b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // abort wins over finishing
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (b_zero) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rpt_add_mult.sv
// rpt_add_mult: unsigned multiply by repeated addition.
// Define RPT_MULT_OPERAND_SWAP_EN to loop over min(a,b).
module rpt_add_mult
  import rpt_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   a_ld;
  logic [WIDTH-1:0]   b_ld;
  logic               b_zero;
  logic               load;
  logic               step;
  logic               latch_p;

`ifdef RPT_MULT_OPERAND_SWAP_EN
  // smaller operand becomes the repeat count
  assign a_ld = (b_in > a_in) ? b_in : a_in;
  assign b_ld = (b_in > a_in) ? a_in : b_in;
`else
  assign a_ld = a_in;
  assign b_ld = b_in;
`endif

  assign b_zero = (b_q == '0);

  rpt_mult_ctrl u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .b_zero  (b_zero),
    .load    (load),
    .step    (step),
    .latch_p (latch_p),
    .ready   (ready),
    .busy    (busy),
    .done    (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      product <= '0;
    end else begin
      if (load) begin
        a_q   <= a_ld;
        b_q   <= b_ld;
        acc_q <= '0;
      end else if (step) begin
        acc_q <= acc_q + {{WIDTH{1'b0}}, a_q};
        b_q   <= b_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end
      if (latch_p) begin
        product <= acc_q;
      end
    end
  end

endmodule

// File: tb/tb_rpt_add_mult.sv
// tb_rpt_add_mult: vector table, corner sequences, random and
// back-to-back operations against a plain-arithmetic model.
module tb_rpt_add_mult;

  localparam int W     = 8;
  localparam int LIMIT = 600;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int tests;
  int fails;

  typedef struct {
    int a;
    int b;
    int p;
  } vec_t;

  typedef struct {
    int a;
    int b;
  } op_t;

  vec_t vecs[6];
  op_t  q[$];

  rpt_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // cycle (1 = first after accept edge) in which done rises
  function automatic int model_cyc(input int a, input int b);
    int n;
    n = b;
`ifdef RPT_MULT_OPERAND_SWAP_EN
    n = (a < b) ? a : b;
`endif
    return n + 2;
  endfunction

  task automatic accept(input int a, input int b);
    a_in  = W'(a);
    b_in  = W'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    while (!done && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ok = done;
  endtask

  task automatic run_op(input string name, input int a, input int b,
                        input int p);
    int cyc;
    bit ok;
    accept(a, b);
    wait_done(cyc, ok);
    check({name, "_done_seen"}, ok, 1);
    check({name, "_latency"}, cyc, model_cyc(a, b));
    check({name, "_product"}, product, p);
    @(posedge clk);
    #1;
    check({name, "_ready_after"}, {ready, busy, done}, 3'b100);
  endtask

  initial begin
    int cyc;
    bit ok;
    int seen_done;
    int got;
    int guard;
    op_t o;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a_in  = '0;
    b_in  = '0;

    vecs[0] = '{a: 5,   b: 3,   p: 15};
    vecs[1] = '{a: 7,   b: 0,   p: 0};
    vecs[2] = '{a: 0,   b: 4,   p: 0};
    vecs[3] = '{a: 255, b: 255, p: 65025};
    vecs[4] = '{a: 2,   b: 200, p: 400};
    vecs[5] = '{a: 12,  b: 13,  p: 156};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_status", {ready, busy, done}, 3'b100);
    check("reset_product", product, 0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);

    // abort in 4th RUN cycle keeps previous product
    run_op("base", 5, 3, 15);
    accept(9, 10);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen_done += int'(done);
    end
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    seen_done += int'(done);
    check("abort_status", {ready, busy, done}, 3'b100);
    check("abort_product", product, 15);
    repeat (12) begin
      @(posedge clk);
      #1;
      seen_done += int'(done);
    end
    check("abort_no_done", seen_done, 0);
    check("abort_still_idle", ready, 1);

    // start while busy is ignored
    accept(6, 7);
    @(posedge clk);
    #1;
    a_in  = 8'd1;
    b_in  = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, ok);
    check("busy_start_done", ok, 1);
    check("busy_start_latency", cyc + 2, model_cyc(6, 7));
    check("busy_start_product", product, 42);
    @(posedge clk);
    #1;
    check("busy_start_idle", {ready, busy}, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_not_queued", {ready, product}, {1'b1, 16'd42});

    for (int i = 0; i < 6; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 40));
      run_op($sformatf("rand%0d", i), ra, rb, ra * rb);
    end

    // start held high, operands change every cycle
    got   = 0;
    guard = 0;
    start = 1'b1;
    a_in  = W'($urandom_range(0, 255));
    b_in  = W'($urandom_range(0, 7));
    while (got < 3 && guard < LIMIT) begin
      if (ready) q.push_back('{a: int'(a_in), b: int'(b_in)});
      @(posedge clk);
      #1;
      guard++;
      if (done) begin
        if (q.size() == 0) begin
          check("b2b_spurious_done", 1, 0);
        end else begin
          o = q.pop_front();
          check($sformatf("b2b%0d_product", got), product, o.a * o.b);
        end
        got++;
      end
      a_in = W'($urandom_range(0, 255));
      b_in = W'($urandom_range(0, 7));
    end
    start = 1'b0;
    check("b2b_count", got, 3);
    guard = 0;
    while (!ready && guard < LIMIT) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("b2b_drain", ready, 1);

    // asynchronous reset in the middle of RUN
    accept(3, 50);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_status", {ready, busy, done}, 3'b100);
    check("midrst_product", product, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_done = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      seen_done += int'(done);
    end
    check("midrst_no_done", seen_done, 0);
    check("midrst_idle", {ready, busy, product}, {2'b10, 16'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
